iob_regarray_2p_ctrl: RTL and testbench
=======================================

Name: iob_regarray_2p_ctrl

Overview:
- CPU-side front end for iob_regarray_2p.
- Accepts byte-addressed IOb-native requests (valid/addr/wdata/wstrb/ready) and produces the regarray write enable plus the packed request {raddr, waddr, wstrb, wdata}.
- Registers the combinational regarray read data into a rvalid/rready response channel.
- Sits between the CPU interconnect and one iob_regarray_2p instance.

Parameters:
- DATA_W, 32, CPU data width; also regarray WDATA_W/RDATA_W; multiple of 8.
- ADDR_W, 8, CPU byte-address width.
- WADDR_W, 8, regarray write-address width (byte granularity).
- RADDR_W, 6, regarray read-address width (word index); ADDR_W-log2(DATA_W/8) is the maximum.
- WSTRB_W, DATA_W/8, strobe width.

Ports:
- clk_i  in  1  clock.
- cke_i  in  1  clock enable; all state holds when low.
- rst_i  in  1  synchronous active-high reset.
- iob_valid_i  in  1  request valid.
- iob_addr_i  in  ADDR_W  byte address.
- iob_wdata_i  in  DATA_W  write data.
- iob_wstrb_i  in  WSTRB_W  byte strobes; nonzero = write, zero = read.
- iob_ready_o  out  1  request accepted this cycle when high with valid.
- iob_rvalid_o  out  1  read data valid.
- iob_rdata_o  out  DATA_W  read data.
- iob_rready_i  in  1  CPU consumes read data.
- wen_o  out  1  to regarray wen_i.
- req_o  out  RADDR_W+WADDR_W+WSTRB_W+DATA_W  to regarray req_i, packed {raddr, waddr, wstrb, wdata}, MSB first.
- resp_i  in  DATA_W  from regarray resp_o.
- err_o  out  1  sticky error; feature-dependent, see Optional Feature.

Behaviour:
- Reset (rst_i=1 at a clk_i edge with cke_i=1): state IDLE; iob_rvalid_o=0, iob_rdata_o=0, wen_o=0, req_o=0, err_o=0.
- Reset mid-read drops the pending response; rvalid is never asserted for it.
- FSM states: IDLE, WRITE, READ, RESP. Encoding 2 bits.
- iob_ready_o=1 only in IDLE. It is combinational from state only, never from valid.
- IDLE + valid + wstrb!=0 -> WRITE:
  - Latch waddr = iob_addr_i[WADDR_W-1:0] with the low log2(WSTRB_W) bits cleared. The regarray adds the strobe's trailing-zero count itself.
  - Latch wstrb and wdata.
- WRITE: wen_o=1 for exactly one cycle; -> IDLE. Write latency is 1 cycle from accept to wen_o, so the register updates at the following edge.
- IDLE + valid + wstrb==0 -> READ: latch raddr = iob_addr_i[log2(WSTRB_W)+:RADDR_W].
- READ: req_o carries raddr. Capture resp_i into iob_rdata_o at the end of this cycle; -> RESP.
- RESP: iob_rvalid_o=1 and rdata stable. On iob_rready_i=1 -> IDLE with rvalid low next cycle. Otherwise hold indefinitely.
- Read latency: rvalid rises 2 cycles after accept. Minimum accept-to-accept interval is 2 cycles for writes and 3 cycles for reads (with rready held high).
- req_o fields hold their last latched value outside WRITE/READ. wstrb in req_o is forced to 0 outside WRITE.
- Address bits above WADDR_W/RADDR_W are ignored; out-of-range indices wrap modulo 2^width.
- cke_i=0: no transitions, no wen_o pulse (wen_o is gated by cke_i).
- A read followed immediately by a write to the same word sees the old data.
- A write followed by a read returns the new data, because wen_o precedes the READ cycle.

Optional Feature:
- Macro: IOB_REGARRAY_2P_CTRL_WSTRB_CHECK_EN.
- Defined:
  - A write whose strobe is not a contiguous run of ones aligned to its own width is accepted. Valid examples for DATA_W=32: 0001, 0010, 0011, 1100, 1111.
  - Such a write produces no wen_o pulse (WRITE state still taken) and sets err_o.
  - err_o is cleared only by reset.
- Undefined: all writes pass through unchecked; err_o is tied to 0.

Decomposition:
- Shared package iob_regarray_2p_ctrl_pkg holds:
  - FSM state localparams IDLE=0, WRITE=1, READ=2, RESP=3.
  - Field offsets for req packing: WDATA_LSB=0, WSTRB_LSB=DATA_W, WADDR_LSB=DATA_W+WSTRB_W, RADDR_LSB=WADDR_LSB+WADDR_W.
- One natural sub-module is iob_wstrb_check: combinational strobe-legality function, instantiated only under the macro.
- State and data registers use iob_reg_cae-style flops with a synchronous reset wrapper.

Test Plan:
- Write addr=0x08, wdata=0xDEADBEEF, wstrb=1111 -> wen_o high exactly one cycle later; req waddr=0x08, wstrb=1111; ready low that cycle.
- Read addr=0x08 with resp_i modeled by a regarray holding 0xDEADBEEF -> raddr=2; rvalid 2 cycles after accept; rdata=0xDEADBEEF.
- Read with rready held 0 for 5 cycles -> rvalid and rdata stable; ready low throughout; the next request is accepted only after the rready cycle.
- Back-to-back: write 0x04=0x1234, then read 0x04 -> returns 0x1234, accepts separated by 2 cycles.
- rst_i asserted in RESP -> rvalid=0 next cycle, state IDLE, ready=1; no stale response appears afterwards.
- With the macro defined, write wstrb=0110 -> no wen_o pulse, err_o=1 sticky. Then wstrb=0011 -> wen_o pulses, err_o stays 1.

Source files
------------

// File: rtl/iob_regarray_2p_ctrl_pkg.sv
// iob_regarray_2p_ctrl_pkg: FSM states and req_o field offsets shared by the regarray front end.
package iob_regarray_2p_ctrl_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, RESP = 2'd3} state_t;
   localparam int WDATA_LSB = 0;
   function automatic int wstrb_lsb(input int data_w);
      return data_w;
   endfunction
   function automatic int waddr_lsb(input int data_w);
      return data_w + data_w / 8;
   endfunction
   function automatic int raddr_lsb(input int data_w, input int waddr_w);
      return waddr_lsb(data_w) + waddr_w;
   endfunction
endpackage

// File: rtl/iob_wstrb_check.sv
// iob_wstrb_check: flags a strobe as legal when it is a power-of-two run of ones aligned to its own width.
module iob_wstrb_check #(
   parameter int WSTRB_W = 4
) (
   input  logic [WSTRB_W-1:0] strb,
   output logic               ok
);
   always_comb begin
      ok = 1'b0;
      for (int s = 1; s <= WSTRB_W; s = s * 2)
         for (int o = 0; o < WSTRB_W; o = o + s)
            if (strb == WSTRB_W'(((64'd1 << s) - 64'd1) << o)) ok = 1'b1;
   end
endmodule

// File: rtl/iob_regarray_2p_ctrl.sv
// iob_regarray_2p_ctrl: IOb-native CPU front end for iob_regarray_2p (write enable, packed req, registered read response).
// Define IOB_REGARRAY_2P_CTRL_WSTRB_CHECK_EN to suppress writes with illegal strobes and raise sticky err_o.
module iob_regarray_2p_ctrl
   import iob_regarray_2p_ctrl_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 8,
   parameter int WADDR_W = 8,
   parameter int RADDR_W = 6,
   parameter int WSTRB_W = DATA_W / 8
) (
   input  logic                                       clk_i,
   input  logic                                       cke_i,
   input  logic                                       rst_i,
   input  logic                                       iob_valid_i,
   input  logic [ADDR_W-1:0]                          iob_addr_i,
   input  logic [DATA_W-1:0]                          iob_wdata_i,
   input  logic [WSTRB_W-1:0]                         iob_wstrb_i,
   output logic                                       iob_ready_o,
   output logic                                       iob_rvalid_o,
   output logic [DATA_W-1:0]                          iob_rdata_o,
   input  logic                                       iob_rready_i,
   output logic                                       wen_o,
   output logic [RADDR_W+WADDR_W+WSTRB_W+DATA_W-1:0]  req_o,
   input  logic [DATA_W-1:0]                          resp_i,
   output logic                                       err_o
);
   localparam int SB = $clog2(WSTRB_W);
   localparam int WSTRB_LSB = wstrb_lsb(DATA_W);
   localparam int WADDR_LSB = waddr_lsb(DATA_W);
   localparam int RADDR_LSB = raddr_lsb(DATA_W, WADDR_W);

   state_t state, state_n;
   logic [WADDR_W-1:0] waddr_q;
   logic [WSTRB_W-1:0] wstrb_q;
   logic [DATA_W-1:0]  wdata_q, rdata_q;
   logic [RADDR_W-1:0] raddr_q;
   logic               wok_q;
   logic               acc_w, acc_r;

   assign acc_w = iob_valid_i & (state == IDLE) & (|iob_wstrb_i);
   assign acc_r = iob_valid_i & (state == IDLE) & ~(|iob_wstrb_i);

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    state_n = acc_w ? WRITE : acc_r ? READ : IDLE;
         WRITE:   state_n = IDLE;
         READ:    state_n = RESP;
         RESP:    state_n = iob_rready_i ? IDLE : RESP;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (cke_i) begin
         if (rst_i) begin
            state   <= IDLE;
            waddr_q <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            raddr_q <= '0;
            rdata_q <= '0;
         end else begin
            state <= state_n;
            if (acc_w) begin
               // word-align here; the regarray re-adds the strobe offset itself
               waddr_q <= iob_addr_i[WADDR_W-1:0] & ~WADDR_W'((1 << SB) - 1);
               wstrb_q <= iob_wstrb_i;
               wdata_q <= iob_wdata_i;
            end
            if (acc_r) raddr_q <= iob_addr_i[SB+:RADDR_W];
            if (state == READ) rdata_q <= resp_i;
         end
      end
   end

`ifdef IOB_REGARRAY_2P_CTRL_WSTRB_CHECK_EN
   logic strb_ok, err_q;
   iob_wstrb_check #(.WSTRB_W(WSTRB_W)) u_wstrb_check (.strb(iob_wstrb_i), .ok(strb_ok));
   always_ff @(posedge clk_i) begin
      if (cke_i) begin
         if (rst_i) begin
            wok_q <= 1'b0;
            err_q <= 1'b0;
         end else if (acc_w) begin
            wok_q <= strb_ok;
            err_q <= err_q | ~strb_ok;
         end
      end
   end
   assign err_o = err_q;
`else
   assign wok_q = 1'b1;
   assign err_o = 1'b0;
`endif

   assign iob_ready_o  = state == IDLE;
   assign iob_rvalid_o = state == RESP;
   assign iob_rdata_o  = rdata_q;
   assign wen_o        = cke_i & (state == WRITE) & wok_q;

   always_comb begin
      req_o = '0;
      req_o[WDATA_LSB+:DATA_W]  = wdata_q;
      req_o[WSTRB_LSB+:WSTRB_W] = (state == WRITE) ? wstrb_q : '0;
      req_o[WADDR_LSB+:WADDR_W] = waddr_q;
      req_o[RADDR_LSB+:RADDR_W] = raddr_q;
   end
endmodule

// File: tb/tb_iob_regarray_2p_ctrl.sv
// tb_iob_regarray_2p_ctrl: directed scoreboard bench with a behavioural regarray behind the controller.
module tb_iob_regarray_2p_ctrl;
   logic        clk = 1'b0, cke, rst, valid, ready, rvalid, rready, wen, err;
   logic [7:0]  addr;
   logic [31:0] wdata, rdata, resp;
   logic [3:0]  wstrb;
   logic [49:0] req;
   logic [31:0] mem [64];
   logic [43:0] exp_wr [$];
   logic [31:0] exp_rd [$];
   int          n_cmp = 0, n_fail = 0, cyc = 0, acc_cyc = 0, t0;

   iob_regarray_2p_ctrl dut (
      .clk_i(clk), .cke_i(cke), .rst_i(rst), .iob_valid_i(valid), .iob_addr_i(addr),
      .iob_wdata_i(wdata), .iob_wstrb_i(wstrb), .iob_ready_o(ready), .iob_rvalid_o(rvalid),
      .iob_rdata_o(rdata), .iob_rready_i(rready), .wen_o(wen), .req_o(req), .resp_i(resp), .err_o(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial for (int i = 0; i < 64; i++) mem[i] = '0;
   assign resp = mem[req[49:44]];
   always @(posedge clk)
      if (wen)
         for (int b = 0; b < 4; b++)
            if (req[32+b]) mem[req[43:38]][8*b+:8] <= req[8*b+:8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (wen) begin
            if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
            else chk("wr_req", req[43:0], exp_wr.pop_front());
         end
         if (rvalid && rready) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_data", rdata, exp_rd.pop_front());
         end
      end
   end

   task automatic do_req(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      @(negedge clk);
      valid = 1'b1; addr = a; wdata = d; wstrb = s;
      while (!ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ready) chk("accept_timeout", 0, 1);
      @(posedge clk);
      acc_cyc = cyc;
      #1 valid = 1'b0;
   endtask

   task automatic wait_rvalid();
      int n = 0;
      @(negedge clk);
      while (!rvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!rvalid) chk("rvalid_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      cke = 1; rst = 1; valid = 0; addr = 0; wdata = 0; wstrb = 0; rready = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_wen", wen, 0);
      chk("rst_req", req, 0);
      chk("rst_err", err, 0);
      rst = 0;
      // full-word write
      exp_wr.push_back({8'h08, 4'hF, 32'hDEADBEEF});
      do_req(8'h08, 32'hDEADBEEF, 4'hF);
      @(negedge clk);
      chk("wr_wen", wen, 1);
      chk("wr_ready_low", ready, 0);
      chk("wr_waddr", req[43:36], 8'h08);
      @(negedge clk);
      chk("wr_wen_one_cycle", wen, 0);
      chk("wr_ready_back", ready, 1);
      chk("wstrb_idle_zero", req[35:32], 0);
      // read back with rready high
      exp_rd.push_back(32'hDEADBEEF);
      do_req(8'h08, 32'h0, 4'h0);
      @(negedge clk);
      chk("rd_rvalid_early", rvalid, 0);
      chk("rd_raddr", req[49:44], 2);
      @(negedge clk);
      chk("rd_rvalid_lat2", rvalid, 1);
      @(posedge clk);
      #1 rready = 0;
      // backpressure: hold rready low for 5 cycles
      exp_rd.push_back(32'hDEADBEEF);
      do_req(8'h08, 32'h0, 4'h0);
      wait_rvalid();
      for (int i = 0; i < 5; i++) begin
         chk("hold_rvalid", rvalid, 1);
         chk("hold_rdata", rdata, 32'hDEADBEEF);
         chk("hold_ready", ready, 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 rready = 1;
      @(posedge clk);
      @(negedge clk);
      chk("hold_release_rvalid", rvalid, 0);
      chk("hold_release_ready", ready, 1);
      // back-to-back write then read
      exp_wr.push_back({8'h04, 4'hF, 32'h00001234});
      exp_rd.push_back(32'h00001234);
      do_req(8'h04, 32'h00001234, 4'hF);
      t0 = acc_cyc;
      do_req(8'h04, 32'h0, 4'h0);
      chk("b2b_accept_gap", acc_cyc - t0, 2);
      wait_rvalid();
      // partial-byte write at an unaligned byte address
      exp_wr.push_back({8'h04, 4'b0010, 32'h0000AB00});
      exp_rd.push_back(32'h0000AB34);
      do_req(8'h05, 32'h0000AB00, 4'b0010);
      do_req(8'h04, 32'h0, 4'h0);
      wait_rvalid();
      @(posedge clk);
      #1 rready = 0;
      // reset while waiting in RESP drops the response
      do_req(8'h08, 32'h0, 4'h0);
      wait_rvalid();
      @(posedge clk);
      #1 rst = 1;
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rstresp_rvalid", rvalid, 0);
      chk("rstresp_ready", ready, 1);
      chk("rstresp_rdata", rdata, 0);
      @(posedge clk);
      #1 rready = 1;
      repeat (4) @(negedge clk);
      // clock enable low stalls the WRITE cycle
      exp_wr.push_back({8'h0C, 4'hF, 32'hCAFEF00D});
      do_req(8'h0C, 32'hCAFEF00D, 4'hF);
      cke = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("cke_wen_gated", wen, 0);
         chk("cke_ready_held", ready, 0);
      end
      @(posedge clk);
      #1 cke = 1;
      @(negedge clk);
      chk("cke_wen_resume", wen, 1);
      exp_rd.push_back(32'hCAFEF00D);
      do_req(8'h0C, 32'h0, 4'h0);
      wait_rvalid();
`ifdef IOB_REGARRAY_2P_CTRL_WSTRB_CHECK_EN
      do_req(8'h10, 32'h11111111, 4'b0110);
      @(negedge clk);
      chk("bad_strb_wen", wen, 0);
      chk("bad_strb_err", err, 1);
      exp_wr.push_back({8'h10, 4'b0011, 32'h0000BEEF});
      do_req(8'h10, 32'h0000BEEF, 4'b0011);
      @(negedge clk);
      chk("good_strb_wen", wen, 1);
      chk("err_sticky", err, 1);
`else
      chk("err_tied_low", err, 0);
`endif
      repeat (5) @(negedge clk);
      chk("wr_queue_drained", exp_wr.size(), 0);
      chk("rd_queue_drained", exp_rd.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
